// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the divider front end.
//   state_t   - controller FSM states
//   OP_QUOT / OP_REM - request opcode encodings
//   DBZ_MAG   - quotient magnitude reported on divide-by-zero
//   req_t     - queued request record {op, tag, a, b}
//   sm_pack   - builds a sign-magnitude word, suppressing negative zero
package div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

  localparam logic OP_QUOT = 1'b0;
  localparam logic OP_REM  = 1'b1;

  localparam logic [30:0] DBZ_MAG = 31'h7FFF_FFFF;

  // The tag field is sized for the widest tag any instance may use; the
  // controller zero-extends on entry and truncates on exit, so TAG_W must
  // not exceed REQ_TAG_MAX.
  localparam int REQ_TAG_MAX = 16;

  typedef struct packed {
    logic                   op;
    logic [REQ_TAG_MAX-1:0] tag;
    logic [31:0]            a;
    logic [31:0]            b;
  } req_t;

  // A zero magnitude always carries a positive sign.
  function automatic logic [31:0] sm_pack(input logic sign, input logic [30:0] mag);
    return {sign & (mag != 31'd0), mag};
  endfunction

endpackage

// File: rtl/div_req_fifo.sv
// div_req_fifo: DEPTH-entry request queue.
//   clk, rst        - clock, synchronous active-high reset (empties the queue)
//   push, push_data - write an entry (ignored while full)
//   pop, pop_data   - head entry is visible on pop_data; pop advances (ignored while empty)
//   full, empty     - occupancy flags
//   count           - number of stored entries, 0..DEPTH
// Simultaneous push and pop are both performed. DEPTH must be a power of two,
// so the pointers wrap by natural overflow.
module div_req_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = logic [7:0],
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            push_ok;
  logic            pop_ok;

  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;

  // Head is read combinationally so the controller can pop and act on the
  // entry in the same IDLE cycle.
  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: request/response front end for the sequential divider.
//   clk, rst                      - clock, synchronous active-high reset
//   req_valid/req_ready           - request handshake; req_ready from registered count
//   req_op, req_tag, req_a, req_b - opcode, writeback tag, sign-magnitude operands
//   div_start, div_a, div_b       - start pulse and operand magnitudes to the divider
//   div_done, div_q, div_r        - divider completion pulse and result magnitudes
//   res_valid/res_ready           - result handshake to writeback
//   res_data, res_tag, res_dbz    - sign-magnitude result, tag, divide-by-zero flag
// One division is in flight at a time; divide-by-zero requests bypass the
// divider and complete straight from IDLE.
module div_ctrl
  import div_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic             div_start,
  output logic [30:0]      div_a,
  output logic [30:0]      div_b,
  input  logic             div_done,
  input  logic [30:0]      div_q,
  input  logic [30:0]      div_r,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_dbz
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t           state_reg, state_next;
  req_t             push_entry;
  req_t             head_entry;
  req_t             work_reg;
  req_t             src_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_pop;
  logic             load_res;
  logic             src_dbz;
  logic [30:0]      q_mag;
  logic [30:0]      r_mag;
  logic [31:0]      res_data_reg, res_data_next;
  logic [TAG_W-1:0] res_tag_reg, res_tag_next;
  logic             res_dbz_reg;

  assign req_ready  = (fifo_count < CNT_W'(DEPTH));

  always_comb begin
    push_entry     = '0;
    push_entry.op  = req_op;
    push_entry.tag = REQ_TAG_MAX'(req_tag);
    push_entry.a   = req_a;
    push_entry.b   = req_b;
  end

  div_req_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (req_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_valid & ~fifo_full),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    load_res   = 1'b0;
    div_start  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_entry.b[30:0] == 31'd0) begin
            load_res   = 1'b1;
            state_next = RESULT;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        div_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (div_done) begin
          load_res   = 1'b1;
          state_next = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Result source: in IDLE the only result ever loaded is a divide-by-zero
  // taken straight from the queue head; otherwise it is the working request
  // combined with the divider's magnitudes.
  always_comb begin
    src_dbz       = (state_reg == IDLE);
    src_entry     = src_dbz ? head_entry : work_reg;
    q_mag         = src_dbz ? DBZ_MAG : div_q;
    r_mag         = src_dbz ? src_entry.a[30:0] : div_r;
    res_tag_next  = TAG_W'(src_entry.tag);
    if (src_entry.op == OP_QUOT) begin
      res_data_next = sm_pack(src_entry.a[31] ^ src_entry.b[31], q_mag);
    end else begin
      res_data_next = sm_pack(src_entry.a[31], r_mag);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_reg     <= '0;
      res_data_reg <= '0;
      res_tag_reg  <= '0;
      res_dbz_reg  <= 1'b0;
    end else begin
      if (fifo_pop) begin
        work_reg <= head_entry;
      end
      if (load_res) begin
        res_data_reg <= res_data_next;
        res_tag_reg  <= res_tag_next;
        res_dbz_reg  <= src_dbz;
      end
    end
  end

  // Operands stay on the working register, which only changes on a pop, so
  // they hold from start until done.
  assign div_a     = work_reg.a[30:0];
  assign div_b     = work_reg.b[30:0];
  assign res_valid = (state_reg == RESULT);
  assign res_data  = res_data_reg;
  assign res_tag   = res_tag_reg;
  assign res_dbz   = res_dbz_reg;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

  localparam int DEPTH = 2;
  localparam int TAG_W = 5;
  localparam int NV    = 13;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic             div_start;
  logic [30:0]      div_a;
  logic [30:0]      div_b;
  logic             div_done = 1'b0;
  logic [30:0]      div_q = '0;
  logic [30:0]      div_r = '0;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_dbz;

  always #5 clk = ~clk;

  div_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_tag   (req_tag),
    .req_a     (req_a),
    .req_b     (req_b),
    .div_start (div_start),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_done  (div_done),
    .div_q     (div_q),
    .div_r     (div_r),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_tag   (res_tag),
    .res_dbz   (res_dbz)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Divider model: done arrives lat+1 cycles after the start cycle.
  // Between completions the result buses carry junk.
  int          lat         = 3;
  int          start_cnt   = 0;
  int          done_cnt    = 0;
  logic        model_busy  = 1'b0;
  int          model_cnt   = 0;
  logic [30:0] cap_a       = '0;
  logic [30:0] cap_b       = '0;

  always @(posedge clk) begin
    div_done <= 1'b0;
    div_q    <= 31'($urandom);
    div_r    <= 31'($urandom);
    if (div_start) begin
      model_busy <= 1'b1;
      model_cnt  <= lat;
      cap_a      <= div_a;
      cap_b      <= div_b;
      start_cnt  <= start_cnt + 1;
    end else if (model_busy) begin
      if (model_cnt == 1) begin
        div_done   <= 1'b1;
        div_q      <= (cap_b != 0) ? cap_a / cap_b : '1;
        div_r      <= (cap_b != 0) ? cap_a % cap_b : cap_a;
        model_busy <= 1'b0;
        done_cnt   <= done_cnt + 1;
      end
      model_cnt <= model_cnt - 1;
    end
  end

  // Operand stability and single-cycle start pulse.
  bit   stab_en    = 1'b1;
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (stab_en && model_busy) begin
      checks++;
      if (div_a !== cap_a || div_b !== cap_b) begin
        errors++;
        $display("FAIL div_operands_stable: got a=%h b=%h expected a=%h b=%h", div_a, div_b, cap_a, cap_b);
      end
    end
    if (div_start) begin
      checks++;
      if (prev_start) begin
        errors++;
        $display("FAIL start_pulse_width: got 2+ cycles expected 1");
      end
    end
    prev_start = div_start;
  end

  // Scoreboard: expected results queued on accept, popped on handshake.
  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             dbz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got tag=%0d data=0x%08h expected none", res_tag, res_data);
      end else begin
        mon_e = sb.pop_front();
        chk("res_data", res_data, mon_e.data);
        chk("res_tag", 32'(res_tag), 32'(mon_e.tag));
        chk("res_dbz", 32'(res_dbz), 32'(mon_e.dbz));
        $display("result tag=%0d data=0x%08h dbz=%0d", res_tag, res_data, res_dbz);
      end
    end
  end

  typedef struct {
    logic             op;
    logic [TAG_W-1:0] tag;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [31:0]      exp_data;
    logic             exp_dbz;
  } vec_t;

  vec_t vecs[NV];

  task automatic send(input vec_t v);
    int guard = 0;
    req_valid = 1'b1;
    req_op    = v.op;
    req_tag   = v.tag;
    req_a     = v.a;
    req_b     = v.b;
    while (!req_ready && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 (tag %0d)", v.tag);
      req_valid = 1'b0;
      return;
    end
    sb.push_back('{v.exp_data, v.tag, v.exp_dbz});
    $display("request tag=%0d op=%0d a=0x%08h b=0x%08h", v.tag, v.op, v.a, v.b);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((sb.size() != 0 || res_valid) && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  int  s0, c, start_c, d0;
  bit  bp_done;

  initial begin
    vecs[0]  = '{1'b0, 5'd3,  32'h0000_0064, 32'h8000_0007, 32'h8000_000E, 1'b0};
    vecs[1]  = '{1'b1, 5'd4,  32'h0000_0064, 32'h8000_0007, 32'h0000_0002, 1'b0};
    vecs[2]  = '{1'b0, 5'd5,  32'h8000_0007, 32'h0000_0007, 32'h8000_0001, 1'b0};
    vecs[3]  = '{1'b1, 5'd6,  32'h8000_0007, 32'h0000_0007, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b0, 5'd7,  32'h8000_0005, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[5]  = '{1'b1, 5'd8,  32'h8000_0005, 32'h0000_0000, 32'h8000_0005, 1'b1};
    vecs[6]  = '{1'b1, 5'd9,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[7]  = '{1'b0, 5'd10, 32'h8000_0000, 32'h0000_0003, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b0, 5'd11, 32'h0000_000A, 32'h0000_0003, 32'h0000_0003, 1'b0};
    vecs[9]  = '{1'b1, 5'd12, 32'h8000_000A, 32'h8000_0003, 32'h8000_0001, 1'b0};
    vecs[10] = '{1'b0, 5'd13, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0};
    vecs[11] = '{1'b0, 5'd14, 32'h0000_0005, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1};
    vecs[12] = '{1'b0, 5'd15, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_tag   = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_div_start", 32'(div_start), 32'd0);
    chk("rst_div_a",     32'(div_a),     32'd0);
    chk("rst_div_b",     32'(div_b),     32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data",  res_data,       32'd0);
    chk("rst_res_tag",   32'(res_tag),   32'd0);
    chk("rst_res_dbz",   32'(res_dbz),   32'd0);

    // Table: each vector alone, varied divider latency.
    for (int i = 0; i < NV; i++) begin
      lat = 1 + (i % 4);
      s0  = start_cnt;
      send(vecs[i]);
      wait_drain();
      chk("start_pulses", 32'(start_cnt - s0), vecs[i].exp_dbz ? 32'd0 : 32'd1);
    end

    // Normal-path latency: start at cycle 2, done at cycle 3+lat, result one later.
    lat = 5;
    send(vecs[0]);
    c = 1;
    start_c = -1;
    while (!res_valid && c < 200) begin
      if (div_start && start_c < 0) start_c = c;
      @(posedge clk); #1;
      c++;
    end
    chk("lat_start_cycle", 32'(start_c), 32'd2);
    chk("lat_result_cycle", 32'(c), 32'(lat + 4));
    wait_drain();

    // Divide-by-zero latency: result at cycle 2.
    send(vecs[4]);
    c = 1;
    while (!res_valid && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk("dbz_result_cycle", 32'(c), 32'd2);
    wait_drain();

    // Backpressure: four requests, writeback stalled, slow divider.
    lat       = 32;
    res_ready = 1'b0;
    bp_done   = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(vecs[i]);
        bp_done = 1'b1;
      end
    join_none
    repeat (45) begin
      @(posedge clk); #1;
    end
    chk("bp_res_valid", 32'(res_valid), 32'd1);
    chk("bp_req_ready", 32'(req_ready), 32'd0);
    chk("bp_accepted",  32'(sb.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_data", res_data, vecs[0].exp_data);
      chk("bp_hold_tag",  32'(res_tag), 32'(vecs[0].tag));
      chk("bp_hold_dbz",  32'(res_dbz), 32'd0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    c = 0;
    while (!bp_done && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
    chk("bp_all_sent", 32'(bp_done), 32'd1);
    wait_drain();

    // Reset while the divider is busy; its late done must be ignored.
    lat = 20;
    send(vecs[8]);
    repeat (6) begin
      @(posedge clk); #1;
    end
    stab_en = 1'b0;
    rst     = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    d0 = done_cnt;
    for (int k = 0; k < 30; k++) begin
      chk("rstw_ctrl", {28'd0, res_valid, div_start, res_dbz, req_ready}, 32'h1);
      chk("rstw_res_data", res_data, 32'd0);
      chk("rstw_div_a", 32'(div_a), 32'd0);
      @(posedge clk); #1;
    end
    chk("rstw_late_done_seen", 32'(done_cnt != d0), 32'd1);
    stab_en = 1'b1;
    lat = 2;
    send(vecs[9]);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Request/response front end for the sequential `divider`. Sits between the execute stage and the divider:
- Accepts sign-magnitude operand pairs with a writeback tag and queues them.
- Issues operand magnitudes to the divider one at a time.
- Applies sign correction to the quotient or remainder, and handles divide-by-zero without involving the divider.
- Presents a tagged result to writeback through a valid/ready handshake.

## Interface
Parameters:
- DEPTH, 2, request queue entries (power of two, ≥2)
- TAG_W, 5, writeback tag width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request offered
- req_ready  out  1  queue can accept; `count < DEPTH` from registered count only
- req_op  in  1  0 = quotient, 1 = remainder
- req_tag  in  TAG_W  writeback tag
- req_a  in  32  dividend, sign-magnitude (bit 31 sign, 30:0 magnitude)
- req_b  in  32  divisor, sign-magnitude
- div_start  out  1  one-cycle start pulse to divider
- div_a  out  31  dividend magnitude, held stable from start until done
- div_b  out  31  divisor magnitude, held stable from start until done
- div_done  in  1  divider result valid (single-cycle pulse)
- div_q  in  31  quotient magnitude
- div_r  in  31  remainder magnitude
- res_valid  out  1  result available
- res_ready  in  1  writeback accepts
- res_data  out  32  sign-magnitude result
- res_tag  out  TAG_W  tag of result
- res_dbz  out  1  divide-by-zero flag, qualified by res_valid

## Operation
- Request enqueues when `req_valid & req_ready`. FIFO order is preserved end to end.
- FSM states:
  - IDLE: if the queue is non-empty, pop the head into the working register. If the divisor magnitude is 0, go to RESULT. Otherwise go to ISSUE.
  - ISSUE: assert div_start for exactly one cycle with div_a/div_b from the working register, then go to WAIT.
  - WAIT: on div_done, latch div_q/div_r and go to RESULT.
  - RESULT: assert res_valid. When res_ready is high, go to IDLE.
- Sign rules:
  - Quotient sign = a[31] ^ b[31].
  - Remainder sign = a[31].
  - Zero magnitude always gets sign 0; no negative zero is ever produced.
- Divide-by-zero (b[30:0] == 0, regardless of b[31]):
  - Quotient = {a[31]^b[31], 31'h7FFFFFFF}.
  - Remainder = a, with the zero-sign rule applied.
  - res_dbz = 1; div_start is never pulsed.
- Ignored events:
  - div_done outside WAIT is ignored.
  - div_q/div_r are sampled only in the cycle where div_done is high.
- Enqueue and dequeue in the same cycle are both performed; count is unchanged.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - req_ready = 1
  - div_start = 0, div_a = 0, div_b = 0
  - res_valid = 0, res_data = 0, res_tag = 0, res_dbz = 0
  - Queue empty, FSM in IDLE
- Reset mid-operation (any state) discards all queued and in-flight requests. A div_done that arrives afterwards is ignored, because the FSM is in IDLE.
- Latency with an empty queue and res_ready high:
  - Request accepted at cycle 0.
  - Popped in IDLE at cycle 1.
  - div_start at cycle 2.
  - If div_done arrives at cycle 2+N, res_valid is asserted at cycle 3+N.
- Divide-by-zero path: res_valid at cycle 2.
- While res_valid is high and res_ready is low, res_data, res_tag and res_dbz stay stable. The queue keeps accepting until full.
- Throughput is one division at a time. The next pop happens in the IDLE cycle following a res_ready handshake.

## Structure
- Package `div_pkg`:
  - State enum IDLE/ISSUE/WAIT/RESULT.
  - Op encodings OP_QUOT = 0, OP_REM = 1.
  - DBZ_MAG = 31'h7FFFFFFF.
  - Request struct {op, tag, a, b}.
- Sub-module `div_req_fifo`: parameterised DEPTH × request-struct FIFO with push, pop, full, empty and count.
- Sign fixup and divide-by-zero muxing are inline combinational logic feeding the result registers.

## Test plan
- a=0x00000064 (+100), b=0x80000007 (−7):
  - op=quot, tag=3, divider model returns q=14, r=2 → res_data=0x8000000E, res_tag=3, res_dbz=0.
  - Same operands, op=rem → res_data=0x00000002.
- Zero-sign rule: a=0x80000007 (−7), b=0x00000007, model q=1, r=0:
  - quot → 0x80000001.
  - rem → 0x00000000, not 0x80000000.
- Divide-by-zero: a=0x80000005, b=0x80000000, op=quot → div_start never pulses; res_data=0x7FFFFFFF; res_dbz=1; res_valid 2 cycles after accept.
- Backpressure: 4 back-to-back requests with res_ready=0 and a 32-cycle divider model:
  - The first request completes and holds at res_valid.
  - Queue accepts the next 2 requests, then req_ready=0.
  - Release res_ready → all 4 results drain in order with the correct tags.
- Reset mid-WAIT: assert rst for 1 cycle while the divider is busy, then drive div_done → no res_valid, all outputs stay at reset values, and the next request completes normally.
